// File: rtl/vga_frame_capture_if.sv
// Write port of the 320x240x12 frame block RAM, as driven by the capture path.
interface vga_frame_capture_if;
  logic        wea;
  logic [16:0] addra;
  logic [11:0] dina;

  modport master (output wea, addra, dina);
  modport slave  (input  wea, addra, dina);
endinterface

// File: rtl/vga_frame_capture.sv
// Samples an incoming VGA stream, recovers pixel/line position from the sync edges,
// 2x2-decimates the active area and writes one full frame into the frame RAM per request.
module vga_frame_capture #(
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       hsync_i,
  input  logic                       vsync_i,
  input  logic [11:0]                pixel_in_i,
  input  logic                       capture_start_i,
  vga_frame_capture_if.master        ram,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic                       abort_o,
  output logic                       locked_o
);

  localparam int unsigned H_OFF  = H_SYNC + H_BP;
  localparam int unsigned V_OFF  = V_SYNC + V_BP;
  localparam int unsigned V_END  = V_OFF + V_ACTIVE;
  localparam int unsigned STRIDE = H_ACTIVE / 2;
  localparam int unsigned LW     = $clog2(LOCK_LINES + 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_e;

  logic        hs_s1_q, vs_s1_q, hs_s2_q, vs_s2_q;
  logic [11:0] pix_s1_q;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  state_e      state_q, state_d;
  logic        wea_q, wea_d, frame_done_q, frame_done_d, abort_q, abort_d;
  logic [16:0] addra_q, addra_d;
  logic [11:0] dina_q;

  logic       hs_fall, vs_fall, locked, x_act, y_act;
  logic [9:0] x, y;

  assign hs_fall = hs_s2_q & ~hs_s1_q;
  assign vs_fall = vs_s2_q & ~vs_s1_q;
  assign locked  = (lock_cnt_q == LW'(LOCK_LINES));

  // Counters are resolved combinationally so the position lines up with the pixel now in s1.
  always_comb begin
    h_cnt_d = hs_fall ? '0 : ((h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 10'd1);
    v_cnt_d = v_cnt_q;
    if (vs_fall) begin
      v_cnt_d = '0;
    end else if (hs_fall && v_cnt_q != '1) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end

    lock_cnt_d = lock_cnt_q;
    if (hs_fall) begin
      if (h_cnt_q == 10'(H_TOTAL - 1)) begin
        lock_cnt_d = locked ? lock_cnt_q : lock_cnt_q + LW'(1);
      end else begin
        lock_cnt_d = '0;
      end
    end else if (h_cnt_d == '1) begin
      lock_cnt_d = '0;
    end
  end

  always_comb begin
    x       = h_cnt_d - 10'(H_OFF);
    y       = v_cnt_d - 10'(V_OFF);
    x_act   = (h_cnt_d >= 10'(H_OFF)) && (h_cnt_d < 10'(H_OFF + H_ACTIVE));
    y_act   = (v_cnt_d >= 10'(V_OFF)) && (v_cnt_d < 10'(V_END));
    wea_d   = (state_q == CAPTURE) && locked && x_act && y_act && !x[0] && !y[0];
    addra_d = 17'(y[9:1]) * 17'(STRIDE) + 17'(x[9:1]);
  end

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    unique case (state_q)
      IDLE:    if (capture_start_i) state_d = ARM;
      ARM:     if (vs_fall && locked) state_d = CAPTURE;
      CAPTURE: begin
        if (!locked) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (hs_fall && v_cnt_d == 10'(V_END)) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hs_s1_q      <= 1'b1;
      vs_s1_q      <= 1'b1;
      hs_s2_q      <= 1'b1;
      vs_s2_q      <= 1'b1;
      pix_s1_q     <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      lock_cnt_q   <= '0;
      state_q      <= IDLE;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      hs_s1_q      <= hsync_i;
      vs_s1_q      <= vsync_i;
      hs_s2_q      <= hs_s1_q;
      vs_s2_q      <= vs_s1_q;
      pix_s1_q     <= pixel_in_i;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      state_q      <= state_d;
      wea_q        <= wea_d;
      addra_q      <= wea_d ? addra_d : addra_q;
      dina_q       <= wea_d ? pix_s1_q : dina_q;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
    end
  end

  assign ram.wea      = wea_q;
  assign ram.addra    = addra_q;
  assign ram.dina     = dina_q;
  assign busy_o       = (state_q == ARM) || (state_q == CAPTURE);
  assign frame_done_o = frame_done_q;
  assign abort_o      = abort_q;
  assign locked_o     = locked;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench for vga_frame_capture using a scaled-down video timing (48x24 total,
// 32x16 active) so each frame is about 1.2k cycles.
module tb_vga_frame_capture;
  localparam int HS = 8, HBP = 4, HA = 32, HT = 48;
  localparam int VS = 2, VBP = 3, VA = 16, VT = 24;
  localparam int HOFF = HS + HBP, VOFF = VS + VBP;
  localparam int STRIDE = HA / 2, NWR = (HA / 2) * (VA / 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, hsync = 1'b1, vsync = 1'b1, cs = 1'b0;
  logic [11:0] pix = '0;
  logic        busy, fd, ab, locked;

  vga_frame_capture_if ram ();

  vga_frame_capture #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .LOCK_LINES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .hsync_i(hsync), .vsync_i(vsync),
    .pixel_in_i(pix), .capture_start_i(cs), .ram(ram),
    .busy_o(busy), .frame_done_o(fd), .abort_o(ab), .locked_o(locked)
  );

  typedef struct {logic [16:0] a; logic [11:0] d;} wr_t;
  wr_t         exp_q[$];
  logic [11:0] mem [0:NWR-1];
  logic [16:0] last_addr = '0;
  int checks = 0, failures = 0, fd_cnt = 0, ab_cnt = 0, wr_cnt = 0;

  function automatic logic [11:0] pix_of(int x, int y);
    return 12'(x + y * 64);
  endfunction

  // One pixel clock: observe the outputs of the previous edge, then drive the next pixel.
  task automatic drive_pix(input int vline, input int p, input bit cap, input bit start);
    int x, y;
    bit act;
    wr_t e;
    @(negedge clk);
    if (fd === 1'b1) fd_cnt++;
    if (ab === 1'b1) ab_cnt++;
    if (ram.wea === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addra=%0d dina=%h required=no_write", ram.addra, ram.dina);
      end else begin
        e = exp_q.pop_front();
        if (ram.addra !== e.a || ram.dina !== e.d) begin
          failures++;
          $display("FAIL write addra=%0d dina=%h required addra=%0d dina=%h", ram.addra, ram.dina, e.a, e.d);
        end
      end
      if (ram.addra < 17'(NWR)) mem[ram.addra[6:0]] = ram.dina;
      last_addr = ram.addra;
    end
    hsync = (p < HS) ? 1'b0 : 1'b1;
    vsync = (vline < VS) ? 1'b0 : 1'b1;
    cs    = start;
    x     = p - HOFF;
    y     = vline - VOFF;
    act   = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    pix   = act ? pix_of(x, y) : 12'($urandom);
    if (cap && act && (x % 2 == 0) && (y % 2 == 0)) begin
      e.a = 17'((y / 2) * STRIDE + x / 2);
      e.d = pix_of(x, y);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_line(input int vline, input int len, input bit cap, input int cs_p);
    for (int p = 0; p < len; p++) drive_pix(vline, p, cap, p == cs_p);
  endtask

  task automatic send_frame(input bit cap, input int cs_line, input int cs_p,
                            input int bad_line, input int bad_len, input int cap_last);
    for (int v = 0; v < VT; v++)
      send_line(v, (v == bad_line) ? bad_len : HT, cap && (v <= cap_last), (v == cs_line) ? cs_p : -1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      hsync = 1'($urandom); vsync = 1'($urandom); pix = 12'($urandom); cs = 1'($urandom);
    end
    @(posedge clk); #1;
    checks += 7;
    if (ram.wea !== 1'b0)   begin failures++; $display("FAIL rst_wea got=%b exp=0", ram.wea); end
    if (ram.addra !== '0)   begin failures++; $display("FAIL rst_addra got=%0d exp=0", ram.addra); end
    if (ram.dina !== '0)    begin failures++; $display("FAIL rst_dina got=%h exp=0", ram.dina); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (fd !== 1'b0)        begin failures++; $display("FAIL rst_frame_done got=%b exp=0", fd); end
    if (ab !== 1'b0)        begin failures++; $display("FAIL rst_abort got=%b exp=0", ab); end
    if (locked !== 1'b0)    begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) send_line(v, HT, 1'b0, -1);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", locked); end
    send_line(4, HT, 1'b0, -1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL lock_after_4 got=%b exp=1", locked); end
    for (int v = 5; v < VT; v++) send_line(v, HT, 1'b0, -1);
  endtask

  task automatic test_full_capture();
    int f0, w0;
    f0 = fd_cnt; w0 = wr_cnt;
    send_line(0, HT, 1'b0, 20);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_arm got=%b exp=1", busy); end
    for (int v = 1; v < VT; v++) send_line(v, HT, 1'b0, -1);
    send_frame(1'b1, -1, -1, -1, HT, VT - 1);
    checks += 8;
    if (wr_cnt - w0 != NWR)          begin failures++; $display("FAIL full_writes got=%0d exp=%0d", wr_cnt - w0, NWR); end
    if (fd_cnt - f0 != 1)            begin failures++; $display("FAIL full_frame_done got=%0d exp=1", fd_cnt - f0); end
    if (exp_q.size() != 0)           begin failures++; $display("FAIL full_pending got=%0d exp=0", exp_q.size()); end
    if (busy !== 1'b0)               begin failures++; $display("FAIL full_busy_end got=%b exp=0", busy); end
    if (mem[0] !== pix_of(0, 0))     begin failures++; $display("FAIL full_addr0 got=%h exp=%h", mem[0], pix_of(0, 0)); end
    if (mem[STRIDE + 1] !== pix_of(2, 2)) begin failures++; $display("FAIL full_addr_2_2 got=%h exp=%h", mem[STRIDE + 1], pix_of(2, 2)); end
    if (mem[NWR - 1] !== pix_of(HA - 2, VA - 2)) begin failures++; $display("FAIL full_addr_last got=%h exp=%h", mem[NWR - 1], pix_of(HA - 2, VA - 2)); end
    if (last_addr !== 17'(NWR - 1))  begin failures++; $display("FAIL full_last_addr got=%0d exp=%0d", last_addr, NWR - 1); end
  endtask

  task automatic test_bad_timing();
    int f0, w0;
    f0 = fd_cnt; w0 = wr_cnt;
    for (int v = 0; v < VT; v++) send_line(v, HT - 1, 1'b0, (v == 2) ? 20 : -1);
    checks += 2;
    if (locked !== 1'b0) begin failures++; $display("FAIL bad_locked got=%b exp=0", locked); end
    if (busy !== 1'b1)   begin failures++; $display("FAIL bad_busy_arm got=%b exp=1", busy); end
    for (int v = 0; v < VT; v++) send_line(v, HT - 1, 1'b0, -1);
    checks += 3;
    if (wr_cnt != w0)    begin failures++; $display("FAIL bad_no_writes got=%0d exp=0", wr_cnt - w0); end
    if (busy !== 1'b1)   begin failures++; $display("FAIL bad_still_arm got=%b exp=1", busy); end
    if (locked !== 1'b0) begin failures++; $display("FAIL bad_locked2 got=%b exp=0", locked); end
    for (int v = 0; v < 4; v++) send_line(v, HT, 1'b0, -1);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL restore_early got=%b exp=0", locked); end
    send_line(4, HT, 1'b0, -1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL restore_lock got=%b exp=1", locked); end
    for (int v = 5; v < VT; v++) send_line(v, HT, 1'b0, -1);
    send_frame(1'b1, -1, -1, -1, HT, VT - 1);
    checks += 4;
    if (wr_cnt - w0 != NWR) begin failures++; $display("FAIL restore_writes got=%0d exp=%0d", wr_cnt - w0, NWR); end
    if (fd_cnt - f0 != 1)   begin failures++; $display("FAIL restore_frame_done got=%0d exp=1", fd_cnt - f0); end
    if (exp_q.size() != 0)  begin failures++; $display("FAIL restore_pending got=%0d exp=0", exp_q.size()); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL restore_busy got=%b exp=0", busy); end
  endtask

  task automatic test_lock_loss();
    int f0, a0, w0;
    f0 = fd_cnt; a0 = ab_cnt; w0 = wr_cnt;
    send_frame(1'b0, 0, 20, -1, HT, -1);
    send_frame(1'b1, -1, -1, VOFF + 6, HT + 1, VOFF + 6);
    checks += 5;
    if (ab_cnt - a0 != 1)        begin failures++; $display("FAIL loss_abort got=%0d exp=1", ab_cnt - a0); end
    if (fd_cnt != f0)            begin failures++; $display("FAIL loss_frame_done got=%0d exp=0", fd_cnt - f0); end
    if (busy !== 1'b0)           begin failures++; $display("FAIL loss_busy got=%b exp=0", busy); end
    if (exp_q.size() != 0)       begin failures++; $display("FAIL loss_pending got=%0d exp=0", exp_q.size()); end
    if (wr_cnt - w0 != 4 * STRIDE) begin failures++; $display("FAIL loss_writes got=%0d exp=%0d", wr_cnt - w0, 4 * STRIDE); end
  endtask

  task automatic test_midcap_reset();
    int f0, w0;
    f0 = fd_cnt; w0 = wr_cnt;
    send_frame(1'b0, 0, 20, -1, HT, -1);
    for (int v = 0; v <= VOFF + 5; v++) send_line(v, HT, 1'b1, -1);
    for (int p = 0; p < HT; p++) begin
      drive_pix(VOFF + 6, p, 1'b0, 1'b0);
      if (p == 2) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks += 5;
        if (ram.wea !== 1'b0) begin failures++; $display("FAIL mid_rst_wea got=%b exp=0", ram.wea); end
        if (ram.addra !== '0) begin failures++; $display("FAIL mid_rst_addra got=%0d exp=0", ram.addra); end
        if (ram.dina !== '0)  begin failures++; $display("FAIL mid_rst_dina got=%h exp=0", ram.dina); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        if (locked !== 1'b0)  begin failures++; $display("FAIL mid_rst_locked got=%b exp=0", locked); end
        rst_n = 1'b1;
      end
    end
    for (int v = VOFF + 7; v < VT; v++) send_line(v, HT, 1'b0, -1);
    checks += 4;
    if (fd_cnt != f0)              begin failures++; $display("FAIL mid_frame_done got=%0d exp=0", fd_cnt - f0); end
    if (exp_q.size() != 0)         begin failures++; $display("FAIL mid_pending got=%0d exp=0", exp_q.size()); end
    if (wr_cnt - w0 != 3 * STRIDE) begin failures++; $display("FAIL mid_writes got=%0d exp=%0d", wr_cnt - w0, 3 * STRIDE); end
    if (busy !== 1'b0)             begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    w0 = wr_cnt;
    send_frame(1'b0, 0, 20, -1, HT, -1);
    send_frame(1'b1, -1, -1, -1, HT, VT - 1);
    checks += 3;
    if (fd_cnt - f0 != 1)   begin failures++; $display("FAIL mid_recap_done got=%0d exp=1", fd_cnt - f0); end
    if (wr_cnt - w0 != NWR) begin failures++; $display("FAIL mid_recap_writes got=%0d exp=%0d", wr_cnt - w0, NWR); end
    if (exp_q.size() != 0)  begin failures++; $display("FAIL mid_recap_pending got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_races();
    int f0, w0;
    f0 = fd_cnt; w0 = wr_cnt;
    send_frame(1'b0, 0, 1, -1, HT, -1);
    send_frame(1'b1, VOFF + 5, 5, -1, HT, VT - 1);
    send_frame(1'b0, -1, -1, -1, HT, -1);
    checks += 4;
    if (fd_cnt - f0 != 1)   begin failures++; $display("FAIL race_frame_done got=%0d exp=1", fd_cnt - f0); end
    if (wr_cnt - w0 != NWR) begin failures++; $display("FAIL race_writes got=%0d exp=%0d", wr_cnt - w0, NWR); end
    if (exp_q.size() != 0)  begin failures++; $display("FAIL race_pending got=%0d exp=0", exp_q.size()); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL race_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_bad_timing();
    test_lock_loss();
    test_midcap_reset();
    test_races();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
